// File: rtl/unidade_load_store.sv
// Load/store unit: captures a request from the control unit, checks
// alignment and legality, runs one memory handshake with a timeout, and
// returns an extended load result. Memory is a 64-bit doubleword port
// with byte strobes.
module unidade_load_store #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [63:0] rdata,
    output logic        erro_alinh,
    output logic        erro_timeout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata
);

    // state   | meaning
    // IDLE    | waiting for start
    // ACESSO  | mem_req held, waiting for mem_ack or timeout
    // CONCLUI | one-cycle done pulse, results valid
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACESSO  = 2'd1,
        CONCLUI = 2'd2
    } estado_t;

    localparam logic [7:0] LIM_ESPERA = 8'(MAX_WAIT - 1);

    estado_t     estado_q, estado_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [63:0] rdata_q, rdata_d;
    logic        erro_alinh_q, erro_alinh_d;
    logic        erro_timeout_q, erro_timeout_d;

    logic [63:0] lido_desloc;
    logic [63:0] lido_ext;
    logic [7:0]  mascara;

    // Illegal encodings and offsets that are not a multiple of the access size
    function automatic logic acesso_invalido(input logic e_we, input logic [2:0] f3,
                                             input logic [2:0] off);
        logic inv;
        inv = 1'b0;
        if (f3 == 3'b111 || (e_we && f3[2]))
            inv = 1'b1;
        else begin
            case (f3[1:0])
                2'b00:   inv = 1'b0;
                2'b01:   inv = off[0];
                2'b10:   inv = |off[1:0];
                default: inv = |off;
            endcase
        end
        return inv;
    endfunction

    // Load lane extraction and sign/zero extension from the captured offset
    always_comb begin
        lido_desloc = mem_rdata >> {addr_q[2:0], 3'b000};
        case (funct3_q)
            3'b000:  lido_ext = {{56{lido_desloc[7]}},  lido_desloc[7:0]};
            3'b001:  lido_ext = {{48{lido_desloc[15]}}, lido_desloc[15:0]};
            3'b010:  lido_ext = {{32{lido_desloc[31]}}, lido_desloc[31:0]};
            3'b100:  lido_ext = {56'd0, lido_desloc[7:0]};
            3'b101:  lido_ext = {48'd0, lido_desloc[15:0]};
            3'b110:  lido_ext = {32'd0, lido_desloc[31:0]};
            default: lido_ext = lido_desloc;
        endcase
    end

    // Next-state, capture, wait counter and result/error registers
    always_comb begin
        estado_d       = estado_q;
        we_d           = we_q;
        funct3_d       = funct3_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        cnt_d          = cnt_q;
        rdata_d        = rdata_q;
        erro_alinh_d   = erro_alinh_q;
        erro_timeout_d = erro_timeout_q;
        case (estado_q)
            IDLE: begin
                if (start) begin
                    we_d           = we;
                    funct3_d       = funct3;
                    addr_d         = addr;
                    wdata_d        = wdata;
                    cnt_d          = 8'd0;
                    erro_timeout_d = 1'b0;
                    erro_alinh_d   = acesso_invalido(we, funct3, addr[2:0]);
                    estado_d       = erro_alinh_d ? CONCLUI : ACESSO;
                end
            end
            ACESSO: begin
                if (mem_ack) begin
                    if (!we_q)
                        rdata_d = lido_ext;
                    estado_d = CONCLUI;
                end else if (cnt_q == LIM_ESPERA) begin
                    erro_timeout_d = 1'b1;
                    estado_d       = CONCLUI;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            CONCLUI: estado_d = IDLE;
            default: estado_d = IDLE;
        endcase
    end

    // State and data registers, asynchronously cleared
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q       <= IDLE;
            we_q           <= 1'b0;
            funct3_q       <= 3'd0;
            addr_q         <= 64'd0;
            wdata_q        <= 64'd0;
            cnt_q          <= 8'd0;
            rdata_q        <= 64'd0;
            erro_alinh_q   <= 1'b0;
            erro_timeout_q <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            we_q           <= we_d;
            funct3_q       <= funct3_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            cnt_q          <= cnt_d;
            rdata_q        <= rdata_d;
            erro_alinh_q   <= erro_alinh_d;
            erro_timeout_q <= erro_timeout_d;
        end
    end

    // Size mask for the store strobes
    always_comb begin
        case (funct3_q[1:0])
            2'b00:   mascara = 8'h01;
            2'b01:   mascara = 8'h03;
            2'b10:   mascara = 8'h0F;
            default: mascara = 8'hFF;
        endcase
    end

    // Memory port is driven only in ACESSO, so it is quiet at reset and in IDLE
    always_comb begin
        mem_req   = (estado_q == ACESSO);
        mem_we    = mem_req & we_q;
        mem_addr  = mem_req ? {addr_q[63:3], 3'b000} : 64'd0;
        mem_wdata = mem_we ? (wdata_q << {addr_q[2:0], 3'b000}) : 64'd0;
        mem_wstrb = mem_we ? 8'(mascara << addr_q[2:0]) : 8'd0;
    end

    assign busy         = (estado_q != IDLE);
    assign done         = (estado_q == CONCLUI);
    assign rdata        = rdata_q;
    assign erro_alinh   = erro_alinh_q;
    assign erro_timeout = erro_timeout_q;

endmodule

// File: tb/tb_unidade_load_store.sv
// Directed bench for unidade_load_store with MAX_WAIT=4.
module tb_unidade_load_store;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [63:0] addr = 64'd0;
    logic [63:0] wdata = 64'd0;
    logic        busy, done, erro_alinh, erro_timeout;
    logic [63:0] rdata;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic [63:0] mem_rdata = 64'd0;

    unidade_load_store #(.MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset), .start(start), .we(we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .erro_alinh(erro_alinh), .erro_timeout(erro_timeout),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] mrd;
        int          ack_lat;
        int          e_done;
        int          e_req;
        logic [63:0] e_rdata;
        logic        e_alinh;
        logic        e_tout;
        logic [7:0]  e_strb;
        logic [63:0] e_wdata;
        logic [63:0] e_maddr;
    } vec_t;

    vec_t vecs[$];
    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic w, input logic [2:0] f, input logic [63:0] a,
                       input logic [63:0] wd, input logic [63:0] mr, input int al,
                       input int ed, input int er, input logic [63:0] erd,
                       input logic ea, input logic et, input logic [7:0] es,
                       input logic [63:0] ew, input logic [63:0] ema);
        vec_t v;
        v.we = w; v.f3 = f; v.addr = a; v.wdata = wd; v.mrd = mr; v.ack_lat = al;
        v.e_done = ed; v.e_req = er; v.e_rdata = erd; v.e_alinh = ea; v.e_tout = et;
        v.e_strb = es; v.e_wdata = ew; v.e_maddr = ema;
        vecs.push_back(v);
    endtask

    // Called in the slot just after a rising edge: that slot is cycle 0.
    task automatic txn(input vec_t v, input int idx);
        int done_c;
        int req_c;
        string tag;
        tag = $sformatf("v%0d", idx);
        start = 1'b1; we = v.we; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
        mem_rdata = v.mrd; mem_ack = 1'b0;
        done_c = 0; req_c = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            mem_ack = (c == v.ack_lat);
            #1;
            if (mem_req) begin
                req_c++;
                chk({tag, " mem_addr"}, mem_addr, v.e_maddr);
                chk({tag, " mem_we"}, 64'(mem_we), 64'(v.we));
                chk({tag, " mem_wstrb"}, 64'(mem_wstrb), 64'(v.e_strb));
                chk({tag, " mem_wdata"}, mem_wdata, v.e_wdata);
            end
            if (done && done_c == 0) done_c = c;
            if (done_c != 0 && c > done_c) break;
        end
        mem_ack = 1'b0;
        chk({tag, " done_cycle"}, 64'(done_c), 64'(v.e_done));
        chk({tag, " req_cycles"}, 64'(req_c), 64'(v.e_req));
        chk({tag, " done_single"}, 64'(done), 64'd0);
        chk({tag, " busy_after"}, 64'(busy), 64'd0);
        chk({tag, " rdata"}, rdata, v.e_rdata);
        chk({tag, " erro_alinh"}, 64'(erro_alinh), 64'(v.e_alinh));
        chk({tag, " erro_timeout"}, 64'(erro_timeout), 64'(v.e_tout));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t v;
        //  we f3    addr         wdata                mem_rdata            ack done req  rdata                a  t  strb   mem_wdata            mem_addr
        add(0, 3'b000, 64'h1003, 64'h0,               64'h0000_0000_8000_0000, 1, 2, 1, 64'hFFFF_FFFF_FFFF_FF80, 0, 0, 8'h00, 64'h0, 64'h1000);
        add(0, 3'b100, 64'h1003, 64'h0,               64'h0000_0000_8000_0000, 1, 2, 1, 64'h80,                  0, 0, 8'h00, 64'h0, 64'h1000);
        add(1, 3'b001, 64'h2006, 64'hABCD,            64'h0,                   1, 2, 1, 64'h80,                  0, 0, 8'hC0, 64'hABCD_0000_0000_0000, 64'h2000);
        add(0, 3'b010, 64'h3002, 64'h0,               64'h0,                   1, 1, 0, 64'h80,                  1, 0, 8'h00, 64'h0, 64'h0);
        add(1, 3'b100, 64'h3000, 64'h55,              64'h0,                   0, 1, 0, 64'h80,                  1, 0, 8'h00, 64'h0, 64'h0);
        add(0, 3'b011, 64'h40,   64'h0,               64'h1234,                0, 5, 4, 64'h80,                  0, 1, 8'h00, 64'h0, 64'h40);
        add(0, 3'b001, 64'h42,   64'h0,               64'h0000_0000_F00D_0000, 4, 5, 4, 64'hFFFF_FFFF_FFFF_F00D, 0, 0, 8'h00, 64'h0, 64'h40);
        add(0, 3'b110, 64'h104,  64'h0,               64'h89AB_CDEF_0000_0000, 2, 3, 2, 64'h0000_0000_89AB_CDEF, 0, 0, 8'h00, 64'h0, 64'h100);
        add(0, 3'b010, 64'h104,  64'h0,               64'h89AB_CDEF_0000_0000, 1, 2, 1, 64'hFFFF_FFFF_89AB_CDEF, 0, 0, 8'h00, 64'h0, 64'h100);
        add(1, 3'b000, 64'h7,    64'hFFFF_FFFF_FFFF_FF5A, 64'h0,               3, 4, 3, 64'hFFFF_FFFF_89AB_CDEF, 0, 0, 8'h80, 64'h5A00_0000_0000_0000, 64'h0);
        add(1, 3'b010, 64'h14,   64'h1122_3344_DEAD_BEEF, 64'h0,               1, 2, 1, 64'hFFFF_FFFF_89AB_CDEF, 0, 0, 8'hF0, 64'hDEAD_BEEF_0000_0000, 64'h10);
        add(1, 3'b011, 64'h18,   64'h0123_4567_89AB_CDEF, 64'h0,               1, 2, 1, 64'hFFFF_FFFF_89AB_CDEF, 0, 0, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h18);
        add(0, 3'b111, 64'h0,    64'h0,               64'h0,                   1, 1, 0, 64'hFFFF_FFFF_89AB_CDEF, 1, 0, 8'h00, 64'h0, 64'h0);
        add(0, 3'b011, 64'h20,   64'h0,               64'hCAFE_BABE_1234_5678, 1, 2, 1, 64'hCAFE_BABE_1234_5678, 0, 0, 8'h00, 64'h0, 64'h20);
        add(0, 3'b101, 64'h21,   64'h0,               64'h0,                   0, 1, 0, 64'hCAFE_BABE_1234_5678, 1, 0, 8'h00, 64'h0, 64'h0);

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst rdata", rdata, 64'd0);
        chk("rst mem_req", 64'(mem_req), 64'd0);
        chk("rst mem_wstrb", 64'(mem_wstrb), 64'd0);
        chk("rst errors", 64'({erro_alinh, erro_timeout}), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) txn(vecs[i], i);

        // start while busy (ACESSO and CONCLUI) is ignored
        start = 1'b1; we = 1'b0; funct3 = 3'b011; addr = 64'h48;
        mem_rdata = 64'h0F0E_0D0C_0B0A_0908;
        @(posedge clk); #1;
        start = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 64'h50;
        #1;
        chk("busy_ign addr c1", mem_addr, 64'h48);
        chk("busy_ign we c1", 64'(mem_we), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        chk("busy_ign addr c2", mem_addr, 64'h48);
        @(posedge clk); #1;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0; start = 1'b1;
        #1;
        chk("busy_ign done c4", 64'(done), 64'd1);
        chk("busy_ign rdata", rdata, 64'h0F0E_0D0C_0B0A_0908);
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        chk("busy_ign idle c5", 64'(busy), 64'd0);
        chk("busy_ign req c5", 64'(mem_req), 64'd0);

        // asynchronous reset in ACESSO
        start = 1'b1; we = 1'b0; funct3 = 3'b011; addr = 64'h60;
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        chk("rstmid req c1", 64'(mem_req), 64'd1);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("rstmid req", 64'(mem_req), 64'd0);
        chk("rstmid busy", 64'(busy), 64'd0);
        chk("rstmid done", 64'(done), 64'd0);
        chk("rstmid rdata", rdata, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #2;
            chk("rstmid no_done", 64'(done), 64'd0);
        end
        @(posedge clk); #1;
        v.we = 1'b0; v.f3 = 3'b011; v.addr = 64'h10; v.wdata = 64'h0;
        v.mrd = 64'h1122_3344_5566_7788; v.ack_lat = 1; v.e_done = 2; v.e_req = 1;
        v.e_rdata = 64'h1122_3344_5566_7788; v.e_alinh = 1'b0; v.e_tout = 1'b0;
        v.e_strb = 8'h00; v.e_wdata = 64'h0; v.e_maddr = 64'h10;
        txn(v, 99);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
